validity_tracker: RTL and testbench
===================================

VALIDITY_TRACKER -- requirements
Module: validity_tracker

Interface
REQ-001 Parameter WINDOW, default 16, sets the number of sampled cycles per measurement window (2..255).
REQ-002 Parameter MISS_LIMIT, default 3, sets the consecutive-miss count that raises the alarm (1..WINDOW).
REQ-003 Parameter CW, default 8, sets the count width; WINDOW SHALL be at most 2^CW-1.
REQ-004 clk  input  1  sole clock; all state updates on its rising edge.
REQ-005 reset  input  1  asynchronous, active-low reset.
REQ-006 enable  input  1  when high, validity_in is sampled this cycle.
REQ-007 validity_in  input  1  registered match flag from the upstream validity stage (1 = match).
REQ-008 clear  input  1  synchronous abort; returns the block to IDLE.
REQ-009 rd_req  input  1  consumer request to read a completed window.
REQ-010 rd_ack  output  1  one-cycle acknowledge of a window read.
REQ-011 match_count  output  CW  number of matches sampled in the current or held window.
REQ-012 miss_count  output  CW  number of misses sampled in the current or held window.
REQ-013 window_done  output  1  high while a completed window is held.
REQ-014 alarm  output  1  high while in ALARM.
REQ-015 state  output  2  FSM encoding: IDLE=0, COUNT=1, HOLD=2, ALARM=3.

Function
REQ-016 IDLE: counters zero; enable=1 SHALL move to COUNT next cycle with no sample taken.
REQ-017 COUNT, enable=1: increments match_count if validity_in=1, else miss_count; window index +1.
REQ-018 COUNT, consecutive-miss counter: +1 on each miss, zeroed on each match.
REQ-019 COUNT, enable=0: no sample; all counters and state hold.
REQ-020 The sample making consecutive misses equal MISS_LIMIT SHALL move to ALARM next cycle; counts include that sample.
REQ-021 The sample completing WINDOW samples SHALL move to HOLD; window_done=1 from that next cycle; match_count+miss_count=WINDOW.
REQ-022 Window completion and MISS_LIMIT on the same sample: ALARM wins; window_done stays 0.
REQ-023 HOLD: counters frozen, validity_in ignored; rd_req=1 SHALL drive rd_ack=1 for exactly the next cycle, zero counters and window_done in that cycle, and enter COUNT if enable=1, else IDLE.
REQ-024 rd_req in any state other than HOLD SHALL be ignored; rd_ack stays 0.
REQ-025 rd_req held high for multiple cycles SHALL yield a single rd_ack per completed window.
REQ-026 ALARM: alarm=1, counters frozen, rd_req ignored.
REQ-027 clear=1 SHALL, next cycle, force IDLE, zero all counters, and drop window_done, alarm and rd_ack; clear has priority over every other input.
REQ-028 All outputs SHALL be registered; output latency is 1 cycle after the sampling edge.

Reset
REQ-029 reset=0 SHALL immediately and asynchronously force state=IDLE, all counters=0, and rd_ack=window_done=alarm=0.
REQ-030 Deassertion SHALL take effect at the next clk edge; no sample is taken on the first edge after deassertion.
REQ-031 Reset asserted mid-window or mid-handshake SHALL discard all partial counts and pending acknowledges.

Configuration
REQ-032 Macro VALIDITY_ALARM_STICKY_EN defined: ALARM SHALL exit only through clear or reset.
REQ-033 Macro VALIDITY_ALARM_STICKY_EN undefined: in ALARM with enable=1, a sample of validity_in=1 SHALL return to COUNT next cycle.
REQ-034 That return SHALL zero all counters and start a fresh window; the recovering sample is not counted.

Verification
REQ-035 WINDOW=16: enable=1 with 16 samples alternating 1/0 -> HOLD, match_count=8, miss_count=8, window_done=1.
REQ-036 Enter HOLD, then pulse rd_req for 3 cycles -> exactly one rd_ack, counters zero, then state=COUNT.
REQ-037 MISS_LIMIT=3, samples 1,0,0,0 -> alarm=1 one cycle after the 4th sample, match_count=1, miss_count=3.
REQ-038 Samples 0,0,1,0,0 -> no alarm, because the match zeroes the consecutive-miss counter.
REQ-039 In ALARM with sample=1, STICKY_EN defined -> remains in ALARM; STICKY_EN undefined -> COUNT with counters zero.
REQ-040 Reset asserted asynchronously mid-window, and clear asserted on the window-completing sample -> IDLE, all outputs 0, no rd_ack.

Source files
------------

// File: rtl/validity_tracker.sv
// Windowed match/miss counter with consecutive-miss alarm; outputs registered, 1-cycle latency.
// Optional VALIDITY_ALARM_STICKY_EN: when defined, ALARM exits only through clear or reset.
module validity_tracker #(
  parameter int WINDOW     = 16,
  parameter int MISS_LIMIT = 3,
  parameter int CW         = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          enable,
  input  logic          validity_in,
  input  logic          clear,
  input  logic          rd_req,
  output logic          rd_ack,
  output logic [CW-1:0] match_count,
  output logic [CW-1:0] miss_count,
  output logic          window_done,
  output logic          alarm,
  output logic [1:0]    state
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    COUNT = 2'd1,
    HOLD  = 2'd2,
    ALARM = 2'd3
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] consec_q;
  logic [CW-1:0] match_d, miss_d, consec_d;
  logic          rd_ack_d, window_done_d, alarm_d;
  logic [CW-1:0] match_inc, miss_inc, consec_inc;
  logic          limit_hit, window_hit;

  // Candidate counter values if the current cycle is taken as a sample.
  always_comb begin
    match_inc  = match_count + CW'(validity_in);
    miss_inc   = miss_count + CW'(!validity_in);
    consec_inc = validity_in ? '0 : consec_q + CW'(1);
    limit_hit  = (consec_inc == CW'(MISS_LIMIT));
    window_hit = ((match_inc + miss_inc) == CW'(WINDOW));
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (clear) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:  if (enable) state_d = COUNT;
        COUNT: begin
          // Alarm takes precedence when the limit-hitting sample also completes the window.
          if (enable) begin
            if (limit_hit)       state_d = ALARM;
            else if (window_hit) state_d = HOLD;
          end
        end
        HOLD:  if (rd_req) state_d = enable ? COUNT : IDLE;
        ALARM: begin
`ifdef VALIDITY_ALARM_STICKY_EN
          state_d = ALARM;
`else
          if (enable && validity_in) state_d = COUNT;
`endif
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    match_d       = match_count;
    miss_d        = miss_count;
    consec_d      = consec_q;
    rd_ack_d      = !clear && (state_q == HOLD) && rd_req;
    window_done_d = (state_d == HOLD);
    alarm_d       = (state_d == ALARM);
    if (clear || state_d == IDLE) begin
      match_d  = '0;
      miss_d   = '0;
      consec_d = '0;
    end else if (state_q == COUNT && enable) begin
      match_d  = match_inc;
      miss_d   = miss_inc;
      consec_d = consec_inc;
    end else if (state_q != COUNT && state_d == COUNT) begin
      // Leaving HOLD after a read, or recovering from ALARM: start a fresh window.
      match_d  = '0;
      miss_d   = '0;
      consec_d = '0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      match_count <= '0;
      miss_count  <= '0;
      consec_q    <= '0;
      rd_ack      <= 1'b0;
      window_done <= 1'b0;
      alarm       <= 1'b0;
    end else begin
      match_count <= match_d;
      miss_count  <= miss_d;
      consec_q    <= consec_d;
      rd_ack      <= rd_ack_d;
      window_done <= window_done_d;
      alarm       <= alarm_d;
    end
  end

  assign state = state_q;

endmodule

// File: tb/tb_validity_tracker.sv
// Bench for validity_tracker: queue-based reference model, per-cycle compare, directed literal checks.
module tb_validity_tracker;
  localparam int WINDOW     = 16;
  localparam int MISS_LIMIT = 3;
  localparam int CW         = 8;
`ifdef VALIDITY_ALARM_STICKY_EN
  localparam bit STICKY = 1'b1;
`else
  localparam bit STICKY = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset, enable, validity_in, clear, rd_req;
  logic          rd_ack, window_done, alarm;
  logic [CW-1:0] match_count, miss_count;
  logic [1:0]    state;

  int errors = 0;
  int checks = 0;
  bit cmp_en = 1'b0;

  validity_tracker #(.WINDOW(WINDOW), .MISS_LIMIT(MISS_LIMIT), .CW(CW)) dut (
    .clk(clk), .reset(reset), .enable(enable), .validity_in(validity_in),
    .clear(clear), .rd_req(rd_req), .rd_ack(rd_ack), .match_count(match_count),
    .miss_count(miss_count), .window_done(window_done), .alarm(alarm), .state(state)
  );

  always #5 clk = ~clk;

  // Reference model: the current window is a plain list of sampled bits.
  int m_state = 0;
  bit win[$];
  bit m_done = 0, m_alarm = 0, m_ack = 0;

  function automatic int ones();
    int n = 0;
    foreach (win[i]) n += win[i];
    return n;
  endfunction

  function automatic int trailing_misses();
    int n = 0;
    for (int i = win.size() - 1; i >= 0 && win[i] == 1'b0; i--) n++;
    return n;
  endfunction

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_state = 0; win.delete(); m_done = 0; m_alarm = 0; m_ack = 0;
    end else begin
      m_ack = 0;
      if (clear) begin
        m_state = 0; win.delete(); m_done = 0; m_alarm = 0;
      end else begin
        case (m_state)
          0: if (enable) m_state = 1;
          1: if (enable) begin
            win.push_back(validity_in);
            if (trailing_misses() == MISS_LIMIT) begin
              m_state = 3; m_alarm = 1;
            end else if (win.size() == WINDOW) begin
              m_state = 2; m_done = 1;
            end
          end
          2: if (rd_req) begin
            m_ack = 1; m_done = 0; win.delete();
            m_state = enable ? 1 : 0;
          end
          default: if (!STICKY && enable && validity_in) begin
            m_state = 1; m_alarm = 0; win.delete();
          end
        endcase
      end
    end
  end

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (cmp_en) begin
      check("state", int'(state), m_state);
      check("match_count", int'(match_count), ones());
      check("miss_count", int'(miss_count), win.size() - ones());
      check("window_done", int'(window_done), int'(m_done));
      check("alarm", int'(alarm), int'(m_alarm));
      check("rd_ack", int'(rd_ack), int'(m_ack));
    end
  end

  task automatic step(input bit en, input bit v, input bit clr, input bit rq);
    enable = en; validity_in = v; clear = clr; rd_req = rq;
    @(posedge clk);
    #1;
  endtask

  task automatic expect_out(input string tag, input int st, input int mc, input int ms,
                            input int dn, input int al);
    check({tag, ".state"}, int'(state), st);
    check({tag, ".match"}, int'(match_count), mc);
    check({tag, ".miss"}, int'(miss_count), ms);
    check({tag, ".done"}, int'(window_done), dn);
    check({tag, ".alarm"}, int'(alarm), al);
  endtask

  initial begin
    int acks;
    int p;
    reset = 1'b0; enable = 0; validity_in = 0; clear = 0; rd_req = 0;
    @(posedge clk); #1;
    cmp_en = 1'b1;
    step(1, 1, 0, 0);
    expect_out("reset", 0, 0, 0, 0, 0);
    check("reset.ack", int'(rd_ack), 0);
    reset = 1'b1;

    // Alternating window of 16 samples.
    step(1, 0, 0, 0);
    expect_out("enter", 1, 0, 0, 0, 0);
    for (int i = 0; i < WINDOW; i++) step(1, (i % 2) == 0, 0, 0);
    expect_out("alt16", 2, 8, 8, 1, 0);

    // rd_req held for three cycles yields one ack.
    acks = 0;
    for (int i = 0; i < 3; i++) begin
      step(1, 1, 0, 1);
      acks += rd_ack;
      if (i == 0) expect_out("read", 1, 0, 0, 0, 0);
    end
    for (int i = 0; i < 2; i++) begin
      step(0, 0, 0, 0);
      acks += rd_ack;
    end
    check("single_ack", acks, 1);

    // 1,0,0,0 -> alarm on the third consecutive miss.
    step(0, 0, 1, 0);
    expect_out("clear", 0, 0, 0, 0, 0);
    step(1, 0, 0, 0);
    step(1, 1, 0, 0);
    step(1, 0, 0, 0);
    step(1, 0, 0, 0);
    expect_out("two_miss", 1, 1, 2, 0, 0);
    step(1, 0, 0, 0);
    expect_out("alarm", 3, 1, 3, 0, 1);
    step(0, 0, 0, 1);
    check("alarm_rd_ack", int'(rd_ack), 0);
    step(1, 1, 0, 0);
    if (STICKY) expect_out("sticky", 3, 1, 3, 0, 1);
    else        expect_out("recover", 1, 0, 0, 0, 0);

    // 0,0,1,0,0 -> the match breaks the miss run.
    step(0, 0, 1, 0);
    step(1, 0, 0, 0);
    step(1, 0, 0, 0); step(1, 0, 0, 0); step(1, 1, 0, 0); step(1, 0, 0, 0); step(1, 0, 0, 0);
    expect_out("no_alarm", 1, 1, 4, 0, 0);

    // Window completes on the limit-hitting sample: alarm wins.
    step(0, 0, 1, 0);
    step(1, 0, 0, 0);
    for (int i = 0; i < WINDOW; i++) step(1, i < WINDOW - MISS_LIMIT, 0, 0);
    expect_out("alarm_wins", 3, WINDOW - MISS_LIMIT, MISS_LIMIT, 0, 1);

    // Asynchronous reset mid-window.
    step(0, 0, 1, 0);
    step(1, 0, 0, 0);
    for (int i = 0; i < 5; i++) step(1, 1, 0, 0);
    reset = 1'b0;
    #1;
    expect_out("async_rst", 0, 0, 0, 0, 0);
    step(1, 1, 0, 0);
    reset = 1'b1;
    step(1, 1, 0, 0);
    expect_out("first_edge", 1, 0, 0, 0, 0);

    // Clear on the window-completing sample.
    for (int i = 0; i < WINDOW - 1; i++) step(1, 1, 0, 0);
    step(1, 1, 1, 1);
    expect_out("clear_last", 0, 0, 0, 0, 0);
    check("clear_last.ack", int'(rd_ack), 0);

    // Randomized phase with varying match density and occasional resets.
    p = 80;
    for (int n = 0; n < 4000; n++) begin
      if (n % 250 == 0) p = 50 + 15 * int'($urandom_range(0, 3));
      reset = ($urandom_range(0, 199) != 0);
      step($urandom_range(0, 99) < 80, $urandom_range(0, 99) < p,
           $urandom_range(0, 99) < 2, $urandom_range(0, 99) < 30);
    end
    reset = 1'b1;
    step(0, 0, 0, 0);
    @(negedge clk);
    cmp_en = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
